dmem_arbiter: RTL and testbench

Single-port data-memory controller for the MEM stage. Arbitrates the one data memory between the pipeline load/store port and a program/debug loader port. Sequences sub-word stores as read-modify-write (the memory has no byte enables) and returns read data one cycle after acceptance. Drives a stall to the pipeline whenever the pipeline request is not accepted.

---
 rtl/dmem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: single-port data-memory controller for the MEM stage.
// Arbitrates the memory between the pipeline port and the loader port.
// Sub-word stores run as a read-modify-write. Read data comes back one cycle after accept.

// One byte lane of the RMW merge: keep the old byte unless this lane is a store target.
module dmem_lane_merge (
  input  logic [7:0] i_old,
  input  logic [7:0] i_new,
  input  logic       i_sel,
  output logic [7:0] o_byte
);
  assign o_byte = i_sel ? i_new : i_old;
endmodule

module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_p_req,
  input  logic              i_p_we,
  input  logic [1:0]        i_p_size,
  input  logic [ADDR_W-1:0] i_p_addr,
  input  logic [DATA_W-1:0] i_p_wdata,
  output logic              o_p_gnt,
  output logic              o_p_err,
  output logic              o_p_rvalid,
  output logic [DATA_W-1:0] o_p_rdata,
  output logic              o_stall,
  input  logic              i_l_req,
  input  logic              i_l_we,
  input  logic [ADDR_W-1:0] i_l_addr,
  input  logic [DATA_W-1:0] i_l_wdata,
  output logic              o_l_gnt,
  output logic              o_l_rvalid,
  output logic [DATA_W-1:0] o_l_rdata,
  output logic              o_mem_WE,
  output logic              o_mem_RE,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [DATA_W-1:0] o_mem_write_data,
  input  logic [DATA_W-1:0] i_mem_read_data
);
  localparam int NUM_LANES = DATA_W / 8;
  localparam int CW        = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_RMW_RD, S_RMW_WR} state_t;

  // Sub-word store captured at the start of an RMW; only the low half of data can be written.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        size;
    logic [15:0]       wdata;
  } rmw_req_t;

  state_t                             r_state, w_next;
  rmw_req_t                           r_rmw;
  logic [DATA_W-1:0]                  r_merged;
  logic [NUM_LANES-1:0][7:0]          w_merged;
  logic [CW-1:0]                      r_starve;
  logic                               r_p_rvalid, r_l_rvalid;
  logic                               w_p_mis, w_p_sub, w_l_win, w_p_win;
  logic                               w_p_rd, w_l_rd, w_rmw_start;
  logic                               w_unused_lbits;

  // The loader is word-only, so its two low address bits carry no information.
  assign w_unused_lbits = ^i_l_addr[1:0];

  // Request decode: misaligned half/word, and sub-word stores needing RMW.
  assign w_p_mis = ((i_p_size == 2'b01) && i_p_addr[0]) ||
                   (i_p_size[1] && (i_p_addr[1:0] != 2'b00));
  assign w_p_sub = i_p_we && !w_p_mis && !i_p_size[1];
  assign w_l_win = i_l_req && (!i_p_req || (r_starve == CW'(STARVE_MAX)));
  assign w_p_win = i_p_req && !w_l_win;

  // Per-lane merge of the latched store data into the word read back from memory.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic       w_sel;
    logic [7:0] w_new;
    assign w_sel = (r_rmw.size == 2'b00) ? (r_rmw.addr[1:0] == 2'(g))
                                         : (r_rmw.addr[1] == 1'(g / 2));
    assign w_new = (r_rmw.size == 2'b00) ? r_rmw.wdata[7:0] : r_rmw.wdata[8*(g%2) +: 8];
    dmem_lane_merge u_merge (
      .i_old  (i_mem_read_data[8*g +: 8]),
      .i_new  (w_new),
      .i_sel  (w_sel),
      .o_byte (w_merged[g])
    );
  end

  // Next state, grants and memory strobes; everything held low while reset is asserted.
  always_comb begin
    w_next           = r_state;
    o_p_gnt          = 1'b0;
    o_p_err          = 1'b0;
    o_l_gnt          = 1'b0;
    o_mem_WE         = 1'b0;
    o_mem_RE         = 1'b0;
    o_mem_address    = '0;
    o_mem_write_data = '0;
    w_p_rd           = 1'b0;
    w_l_rd           = 1'b0;
    w_rmw_start      = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_IDLE: begin
          if (w_l_win) begin
            o_l_gnt       = 1'b1;
            o_mem_address = {i_l_addr[ADDR_W-1:2], 2'b00};
            if (i_l_we) begin
              o_mem_WE         = 1'b1;
              o_mem_write_data = i_l_wdata;
            end else begin
              o_mem_RE = 1'b1;
              w_l_rd   = 1'b1;
            end
          end else if (w_p_win) begin
            if (w_p_mis) begin
              o_p_gnt = 1'b1;
              o_p_err = 1'b1;
            end else if (w_p_sub) begin
              o_mem_RE      = 1'b1;
              o_mem_address = {i_p_addr[ADDR_W-1:2], 2'b00};
              w_rmw_start   = 1'b1;
              w_next        = S_RMW_RD;
            end else begin
              o_p_gnt       = 1'b1;
              o_mem_address = {i_p_addr[ADDR_W-1:2], 2'b00};
              if (i_p_we) begin
                o_mem_WE         = 1'b1;
                o_mem_write_data = i_p_wdata;
              end else begin
                o_mem_RE = 1'b1;
                w_p_rd   = 1'b1;
              end
            end
          end
        end
        S_RMW_RD: w_next = S_RMW_WR;
        S_RMW_WR: begin
          o_mem_WE         = 1'b1;
          o_mem_address    = {r_rmw.addr[ADDR_W-1:2], 2'b00};
          o_mem_write_data = r_merged;
          o_p_gnt          = 1'b1;
          w_next           = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  assign o_stall    = rst_n & i_p_req & ~o_p_gnt;
  assign o_p_rvalid = r_p_rvalid;
  assign o_l_rvalid = r_l_rvalid;
  assign o_p_rdata  = r_p_rvalid ? i_mem_read_data : '0;
  assign o_l_rdata  = r_l_rvalid ? i_mem_read_data : '0;

  // State, RMW capture and read-valid tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rmw      <= '0;
      r_merged   <= '0;
      r_p_rvalid <= 1'b0;
      r_l_rvalid <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_p_rvalid <= w_p_rd;
      r_l_rvalid <= w_l_rd;
      if (w_rmw_start) begin
        r_rmw.addr  <= i_p_addr;
        r_rmw.size  <= i_p_size;
        r_rmw.wdata <= i_p_wdata[15:0];
      end
      if (r_state == S_RMW_RD) r_merged <= w_merged;
    end
  end

  // Starvation counter: pipeline grants taken in IDLE while the loader is waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (!i_l_req || o_l_gnt) begin
      r_starve <= '0;
    end else if (o_p_gnt && (r_state == S_IDLE) && (r_starve != CW'(STARVE_MAX))) begin
      r_starve <= r_starve + 1'b1;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed table, starvation and reset sequences, random ops.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_p_req, i_p_we;
  logic [1:0]  i_p_size;
  logic [31:0] i_p_addr, i_p_wdata;
  logic        o_p_gnt, o_p_err, o_p_rvalid, o_stall;
  logic [31:0] o_p_rdata;
  logic        i_l_req, i_l_we;
  logic [31:0] i_l_addr, i_l_wdata;
  logic        o_l_gnt, o_l_rvalid;
  logic [31:0] o_l_rdata;
  logic        o_mem_WE, o_mem_RE;
  logic [31:0] o_mem_address, o_mem_write_data;
  logic [31:0] r_mrd;

  int checks = 0;
  int errors = 0;
  int excl_viol = 0;

  logic [31:0] bmem    [0:63];
  logic [31:0] ref_mem [0:63];

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_p_req(i_p_req), .i_p_we(i_p_we), .i_p_size(i_p_size), .i_p_addr(i_p_addr),
    .i_p_wdata(i_p_wdata), .o_p_gnt(o_p_gnt), .o_p_err(o_p_err), .o_p_rvalid(o_p_rvalid),
    .o_p_rdata(o_p_rdata), .o_stall(o_stall),
    .i_l_req(i_l_req), .i_l_we(i_l_we), .i_l_addr(i_l_addr), .i_l_wdata(i_l_wdata),
    .o_l_gnt(o_l_gnt), .o_l_rvalid(o_l_rvalid), .o_l_rdata(o_l_rdata),
    .o_mem_WE(o_mem_WE), .o_mem_RE(o_mem_RE), .o_mem_address(o_mem_address),
    .o_mem_write_data(o_mem_write_data), .i_mem_read_data(r_mrd)
  );

  always #5 clk = ~clk;

  // Synchronous memory without byte enables.
  always @(posedge clk) begin
    if (o_mem_WE) bmem[o_mem_address[7:2]] <= o_mem_write_data;
    if (o_mem_RE) r_mrd <= bmem[o_mem_address[7:2]];
  end

  always @(negedge clk) if (rst_n && o_mem_WE && o_mem_RE) excl_viol++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic logic is_mis(input logic [1:0] sz, input logic [31:0] a);
    return ((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
  endfunction

  // Store effect on a whole word, from the size/offset rules.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] sz,
                                        input logic [31:0] a, input logic [31:0] wd);
    int sh;
    logic [31:0] mask;
    if (sz == 2'b00) begin
      sh = 8 * int'(a[1:0]); mask = 32'hFF << sh;
      return (old & ~mask) | ((wd & 32'hFF) << sh);
    end else if (sz == 2'b01) begin
      sh = 16 * int'(a[1]); mask = 32'hFFFF << sh;
      return (old & ~mask) | ((wd & 32'hFFFF) << sh);
    end
    return wd;
  endfunction

  // One pipeline transaction; returns what the DUT did. Starts and ends at posedge+1.
  task automatic p_op(input logic we, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, output logic err, output int lat,
                      output int stalls, output logic rv, output logic [31:0] rd,
                      output logic en_err);
    logic got = 1'b0;
    err = 1'b0; lat = 0; stalls = 0; en_err = 1'b0;
    i_p_req = 1'b1; i_p_we = we; i_p_size = sz; i_p_addr = a; i_p_wdata = wd;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge clk);
      if (o_stall) stalls++;
      if (o_p_gnt) begin
        got = 1'b1; err = o_p_err; en_err = o_p_err & (o_mem_WE | o_mem_RE);
      end else lat++;
      @(posedge clk); #1;
    end
    i_p_req = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL p_gnt_timeout got=none want=grant addr=%h", a);
    end
    @(negedge clk);
    rv = o_p_rvalid; rd = o_p_rdata;
    @(posedge clk); #1;
  endtask

  // Pipeline op checked against the reference memory.
  task automatic do_pipe(input logic we, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd);
    logic e_err, e_rv, err, rv, en_err;
    logic [31:0] rd;
    int e_lat, lat, st;
    e_err = is_mis(sz, a);
    e_lat = (we && !e_err && !sz[1]) ? 2 : 0;
    e_rv  = !we && !e_err;
    p_op(we, sz, a, wd, err, lat, st, rv, rd, en_err);
    chk("rnd_err", err, e_err);
    chk("rnd_lat", lat, e_lat);
    chk("rnd_stall", st, e_lat);
    chk("rnd_rvalid", rv, e_rv);
    if (e_rv) chk("rnd_rdata", rd, ref_mem[a[7:2]]);
    if (e_err) chk("rnd_err_noen", en_err, 1'b0);
    if (we && !e_err) ref_mem[a[7:2]] = merge(ref_mem[a[7:2]], sz, a, wd);
  endtask

  // Loader op: accepted the same cycle when the pipeline is idle.
  task automatic do_ldr(input logic we, input logic [31:0] a, input logic [31:0] wd);
    int lat = 0;
    logic got = 1'b0;
    i_l_req = 1'b1; i_l_we = we; i_l_addr = a; i_l_wdata = wd;
    for (int c = 0; c < 4 && !got; c++) begin
      @(negedge clk);
      if (o_l_gnt) got = 1'b1; else lat++;
      @(posedge clk); #1;
    end
    i_l_req = 1'b0;
    chk("ldr_lat", lat, 0);
    @(negedge clk);
    chk("ldr_rvalid", o_l_rvalid, !we);
    if (!we) chk("ldr_rdata", o_l_rdata, ref_mem[a[7:2]]);
    @(posedge clk); #1;
    if (we) ref_mem[a[7:2]] = wd;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        e_err;
    int          e_lat;
    logic        e_rv;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vt[17];

  initial begin
    logic err, rv, en_err, lw, pv, lv;
    logic [31:0] rd;
    int lat, st, cnt;

    vt[0]  = '{1'b1, 2'd2, 32'd0,  32'hF000_0000, 1'b0, 0, 1'b0, 32'h0};
    vt[1]  = '{1'b0, 2'd2, 32'd0,  32'h0,         1'b0, 0, 1'b1, 32'hF000_0000};
    vt[2]  = '{1'b1, 2'd2, 32'd8,  32'h1122_3344, 1'b0, 0, 1'b0, 32'h0};
    vt[3]  = '{1'b1, 2'd0, 32'd9,  32'h0000_00AA, 1'b0, 2, 1'b0, 32'h0};
    vt[4]  = '{1'b0, 2'd2, 32'd8,  32'h0,         1'b0, 0, 1'b1, 32'h1122_AA44};
    vt[5]  = '{1'b1, 2'd2, 32'd8,  32'h1122_3344, 1'b0, 0, 1'b0, 32'h0};
    vt[6]  = '{1'b1, 2'd1, 32'd10, 32'h0000_BEEF, 1'b0, 2, 1'b0, 32'h0};
    vt[7]  = '{1'b0, 2'd2, 32'd8,  32'h0,         1'b0, 0, 1'b1, 32'hBEEF_3344};
    vt[8]  = '{1'b1, 2'd1, 32'd11, 32'h1234_5678, 1'b1, 0, 1'b0, 32'h0};
    vt[9]  = '{1'b0, 2'd2, 32'd8,  32'h0,         1'b0, 0, 1'b1, 32'hBEEF_3344};
    vt[10] = '{1'b0, 2'd2, 32'd6,  32'h0,         1'b1, 0, 1'b0, 32'h0};
    vt[11] = '{1'b0, 2'd0, 32'd9,  32'h0,         1'b0, 0, 1'b1, 32'hBEEF_3344};
    vt[12] = '{1'b0, 2'd3, 32'd8,  32'h0,         1'b0, 0, 1'b1, 32'hBEEF_3344};
    vt[13] = '{1'b1, 2'd3, 32'd12, 32'hCAFE_BABE, 1'b0, 0, 1'b0, 32'h0};
    vt[14] = '{1'b0, 2'd1, 32'd14, 32'h0,         1'b0, 0, 1'b1, 32'hCAFE_BABE};
    vt[15] = '{1'b1, 2'd0, 32'd15, 32'h1234_5677, 1'b0, 2, 1'b0, 32'h0};
    vt[16] = '{1'b0, 2'd2, 32'd12, 32'h0,         1'b0, 0, 1'b1, 32'h77FE_BABE};

    for (int i = 0; i < 64; i++) begin bmem[i] = '0; ref_mem[i] = '0; end
    r_mrd = '0;

    // Reset with both requests high: every output must stay low.
    rst_n = 1'b0;
    i_p_req = 1'b1; i_p_we = 1'b0; i_p_size = 2'd2; i_p_addr = '0; i_p_wdata = '0;
    i_l_req = 1'b1; i_l_we = 1'b0; i_l_addr = '0; i_l_wdata = '0;
    #3;
    chk("reset_outs", 32'(|{o_p_gnt, o_p_err, o_p_rvalid, o_p_rdata, o_stall, o_l_gnt,
        o_l_rvalid, o_l_rdata, o_mem_WE, o_mem_RE, o_mem_address, o_mem_write_data}), 32'h0);
    i_p_req = 1'b0; i_l_req = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < 17; i++) begin
      p_op(vt[i].we, vt[i].sz, vt[i].addr, vt[i].wdata, err, lat, st, rv, rd, en_err);
      chk($sformatf("vec%0d_err", i), err, vt[i].e_err);
      chk($sformatf("vec%0d_lat", i), lat, vt[i].e_lat);
      chk($sformatf("vec%0d_stall", i), st, vt[i].e_lat);
      chk($sformatf("vec%0d_rvalid", i), rv, vt[i].e_rv);
      if (vt[i].e_rv) chk($sformatf("vec%0d_rdata", i), rd, vt[i].e_rd);
      if (vt[i].e_err) chk($sformatf("vec%0d_noen", i), en_err, 1'b0);
      if (vt[i].we && !vt[i].e_err)
        ref_mem[vt[i].addr[7:2]] = merge(ref_mem[vt[i].addr[7:2]], vt[i].sz, vt[i].addr, vt[i].wdata);
    end

    // Both ports held: 4 pipeline grants, then the loader, repeating.
    do_ldr(1'b1, 32'h20, 32'hA5A5_0001);
    i_p_req = 1'b1; i_p_we = 1'b0; i_p_size = 2'd2; i_p_addr = 32'd0;
    i_l_req = 1'b1; i_l_we = 1'b0; i_l_addr = 32'h22;
    cnt = 0; pv = 1'b0; lv = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      lw = (cnt == 4);
      chk("arb_p_gnt", o_p_gnt, !lw);
      chk("arb_l_gnt", o_l_gnt, lw);
      chk("arb_stall", o_stall, lw);
      chk("arb_p_rvalid", o_p_rvalid, pv);
      chk("arb_l_rvalid", o_l_rvalid, lv);
      if (pv) chk("arb_p_rdata", o_p_rdata, ref_mem[0]);
      if (lv) chk("arb_l_rdata", o_l_rdata, ref_mem[8]);
      pv = !lw; lv = lw; cnt = lw ? 0 : cnt + 1;
      @(posedge clk); #1;
    end
    i_p_req = 1'b0; i_l_req = 1'b0;
    @(posedge clk); #1;

    // Reset during RMW_RD of a byte store: no write, no grant.
    do_pipe(1'b1, 2'd2, 32'd4, 32'h5566_7788);
    i_p_req = 1'b1; i_p_we = 1'b1; i_p_size = 2'd0; i_p_addr = 32'd4; i_p_wdata = 32'hAA;
    @(negedge clk);
    chk("rmw_start_re", o_mem_RE, 1'b1);
    chk("rmw_start_gnt", o_p_gnt, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rmw_reset_outs", 32'(|{o_p_gnt, o_p_err, o_p_rvalid, o_p_rdata, o_stall, o_l_gnt,
        o_l_rvalid, o_l_rdata, o_mem_WE, o_mem_RE, o_mem_address, o_mem_write_data}), 32'h0);
    @(posedge clk); #1;
    i_p_req = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    do_pipe(1'b0, 2'd2, 32'd4, 32'h0);

    // Random single-port traffic against the reference memory.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) < 7)
        do_pipe(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                32'($urandom_range(0, 255)), $urandom);
      else
        do_ldr(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom);
    end

    chk("we_re_exclusive", excl_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
